// File: rtl/dpram_pkg.sv
// Shared constants and types for the parametrised dual-port RAM.
// Write-mode encodings select what a port's read register shows on its own write.
package dpram_pkg;

    localparam int unsigned WM_NORMAL        = 0;
    localparam int unsigned WM_WRITE_THROUGH = 1;
    localparam int unsigned WM_READ_FIRST    = 2;

    typedef enum logic {
        StIdle,
        StSweep
    } sweep_state_e;

endpackage

// File: rtl/dpram_init_seq.sv
// Post-reset clear sequencer: walks every address once, then parks in idle.
// init_busy trails the FSM state by one edge so the last sweep write is still covered.
module dpram_init_seq
    import dpram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 11,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    output logic                  init_busy,
    output logic                  sweep_we,
    output logic [ADDR_WIDTH-1:0] sweep_addr
);

    sweep_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = (state_q == StSweep);
        if (state_q == StSweep) begin
            cnt_d = cnt_q + ADDR_WIDTH'(1);
            if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
                state_d = StIdle;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= (CLEAR_ON_RESET != 0) ? StSweep : StIdle;
            cnt_q   <= '0;
            busy_q  <= (CLEAR_ON_RESET != 0);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign init_busy  = busy_q;
    assign sweep_we   = (state_q == StSweep);
    assign sweep_addr = cnt_q;

endmodule

// File: rtl/dpram_gen.sv
// Single-clock true dual-port RAM with per-port write modes, optional output
// register, port-A-wins collision handling and an optional post-reset clear sweep.
module dpram_gen
    import dpram_pkg::*;
#(
    parameter int unsigned     DATA_WIDTH     = 8,
    parameter int unsigned     ADDR_WIDTH     = 11,
    parameter int unsigned     OUT_REG        = 1,
    parameter int unsigned     WRITE_MODE_A   = 0,
    parameter int unsigned     WRITE_MODE_B   = 0,
    parameter int unsigned     CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  cea,
    input  logic                  ocea,
    input  logic                  wrea,
    input  logic [ADDR_WIDTH-1:0] ada,
    input  logic [DATA_WIDTH-1:0] dina,
    output logic [DATA_WIDTH-1:0] douta,
    input  logic                  ceb,
    input  logic                  oceb,
    input  logic                  wreb,
    input  logic [ADDR_WIDTH-1:0] adb,
    input  logic [DATA_WIDTH-1:0] dinb,
    output logic [DATA_WIDTH-1:0] doutb,
    output logic                  init_busy,
    output logic                  collision
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  sweep_we;
    logic [ADDR_WIDTH-1:0] sweep_addr;

    dpram_init_seq #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_init_seq (
        .clk        (clk),
        .resetn     (resetn),
        .init_busy  (init_busy),
        .sweep_we   (sweep_we),
        .sweep_addr (sweep_addr)
    );

    logic                  acc_a, acc_b;
    logic                  wr_a, wr_b;
    logic                  col_d, collision_q;
    logic                  mem_we_a, mem_we_b;
    logic [ADDR_WIDTH-1:0] mem_addr_a;
    logic [DATA_WIDTH-1:0] mem_din_a;
    logic                  rd_mem_a, rd_din_a, rd_mem_b, rd_din_b;
    logic [DATA_WIDTH-1:0] rd_a_q, rd_b_q;
    logic [DATA_WIDTH-1:0] out_a_q, out_a_d, out_b_q, out_b_d;

    always_comb begin
        acc_a = cea & ~init_busy;
        acc_b = ceb & ~init_busy;
        wr_a  = acc_a & wrea;
        wr_b  = acc_b & wreb;
        col_d = wr_a & wr_b & (ada == adb);

        // The sweep borrows port A's write path; user accesses are masked meanwhile.
        mem_we_a   = sweep_we | wr_a;
        mem_addr_a = sweep_we ? sweep_addr : ada;
        mem_din_a  = sweep_we ? CLEAR_VALUE : dina;
        mem_we_b   = wr_b & ~col_d;

        rd_mem_a = acc_a & (~wrea | (WRITE_MODE_A == WM_READ_FIRST));
        rd_din_a = wr_a & (WRITE_MODE_A == WM_WRITE_THROUGH);
        rd_mem_b = acc_b & (~wreb | (WRITE_MODE_B == WM_READ_FIRST));
        rd_din_b = wr_b & (WRITE_MODE_B == WM_WRITE_THROUGH);

        out_a_d = ocea ? rd_a_q : out_a_q;
        out_b_d = oceb ? rd_b_q : out_b_q;
    end

    always_ff @(posedge clk) begin
        if (mem_we_a) begin
            mem[mem_addr_a] <= mem_din_a;
        end
        if (mem_we_b) begin
            mem[adb] <= dinb;
        end
    end

    // Read registers sample the array directly so the tools map them into the BSRAM.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_a_q <= '0;
        end else if (rd_mem_a) begin
            rd_a_q <= mem[ada];
        end else if (rd_din_a) begin
            rd_a_q <= dina;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_b_q <= '0;
        end else if (rd_mem_b) begin
            rd_b_q <= mem[adb];
        end else if (rd_din_b) begin
            rd_b_q <= dinb;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_a_q     <= '0;
            out_b_q     <= '0;
            collision_q <= 1'b0;
        end else begin
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            collision_q <= col_d;
        end
    end

    assign douta     = (OUT_REG != 0) ? out_a_q : rd_a_q;
    assign doutb     = (OUT_REG != 0) ? out_b_q : rd_b_q;
    assign collision = collision_q;

endmodule

// File: tb/tb_dpram_gen.sv
// Directed bench for dpram_gen: three 16x8 instances differing only in write mode
// share one stimulus stream, so memory contents match and read registers differ.
module tb_dpram_gen;

    logic       clk = 1'b0;
    logic       resetn;
    logic       cea, ocea, wrea, ceb, oceb, wreb;
    logic [3:0] ada, adb;
    logic [7:0] dina, dinb;

    logic [7:0] douta0, douta1, douta2, doutb0, doutb1, doutb2;
    logic       busy0, busy1, busy2, col0, col1, col2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dpram_gen #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .OUT_REG(1), .WRITE_MODE_A(0),
                .WRITE_MODE_B(0), .CLEAR_ON_RESET(1), .CLEAR_VALUE(8'hA5)) u_dut0 (
        .clk(clk), .resetn(resetn), .cea(cea), .ocea(ocea), .wrea(wrea), .ada(ada),
        .dina(dina), .douta(douta0), .ceb(ceb), .oceb(oceb), .wreb(wreb), .adb(adb),
        .dinb(dinb), .doutb(doutb0), .init_busy(busy0), .collision(col0)
    );

    dpram_gen #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .OUT_REG(1), .WRITE_MODE_A(1),
                .WRITE_MODE_B(1), .CLEAR_ON_RESET(1), .CLEAR_VALUE(8'hA5)) u_dut1 (
        .clk(clk), .resetn(resetn), .cea(cea), .ocea(ocea), .wrea(wrea), .ada(ada),
        .dina(dina), .douta(douta1), .ceb(ceb), .oceb(oceb), .wreb(wreb), .adb(adb),
        .dinb(dinb), .doutb(doutb1), .init_busy(busy1), .collision(col1)
    );

    dpram_gen #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .OUT_REG(1), .WRITE_MODE_A(2),
                .WRITE_MODE_B(2), .CLEAR_ON_RESET(1), .CLEAR_VALUE(8'hA5)) u_dut2 (
        .clk(clk), .resetn(resetn), .cea(cea), .ocea(ocea), .wrea(wrea), .ada(ada),
        .dina(dina), .douta(douta2), .ceb(ceb), .oceb(oceb), .wreb(wreb), .adb(adb),
        .dinb(dinb), .doutb(doutb2), .init_busy(busy2), .collision(col2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cea  = 1'b0;
        ceb  = 1'b0;
        wrea = 1'b0;
        wreb = 1'b0;
    endtask

    task automatic write_a(input logic [3:0] a, input logic [7:0] d);
        cea  = 1'b1;
        wrea = 1'b1;
        ada  = a;
        dina = d;
        step();
        idle();
    endtask

    // Read on both ports, then one more edge so the output register catches up.
    task automatic read_both(input logic [3:0] a, input logic [3:0] b);
        cea  = 1'b1;
        ceb  = 1'b1;
        wrea = 1'b0;
        wreb = 1'b0;
        ada  = a;
        adb  = b;
        step();
        idle();
        step();
    endtask

    task automatic sweep_window(input string tag);
        for (int i = 0; i < 16; i++) begin
            step();
            check_eq(tag, 32'(busy0), 32'd1);
            if (i == 8) check_eq({tag, "_douta_zero"}, 32'(douta0), 32'h0);
        end
        step();
        check_eq({tag, "_end"}, 32'(busy0), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0;
        ocea   = 1'b1;
        oceb   = 1'b1;
        ada    = '0;
        adb    = '0;
        dina   = '0;
        dinb   = '0;
        idle();
        step();
        step();
        check_eq("rst_busy", 32'(busy0), 32'd1);
        check_eq("rst_douta", 32'(douta0), 32'h0);
        check_eq("rst_doutb", 32'(doutb0), 32'h0);
        check_eq("rst_collision", 32'(col0), 32'd0);

        resetn = 1'b1;
        sweep_window("sweep_busy");

        for (int i = 0; i < 16; i++) begin
            read_both(4'(i), 4'(15 - i));
            check_eq("clear_douta", 32'(douta0), 32'hA5);
            check_eq("clear_doutb", 32'(doutb1), 32'hA5);
        end

        // Output register latency and oceb hold.
        write_a(4'd5, 8'h3C);
        ceb = 1'b1;
        adb = 4'd5;
        step();
        idle();
        check_eq("outreg_latency_old", 32'(doutb0), 32'hA5);
        step();
        check_eq("outreg_read5", 32'(doutb0), 32'h3C);
        write_a(4'd6, 8'h66);
        oceb = 1'b0;
        ceb  = 1'b1;
        adb  = 4'd6;
        step();
        idle();
        step();
        step();
        check_eq("oceb_hold", 32'(doutb0), 32'h3C);
        oceb = 1'b1;
        step();
        check_eq("oceb_release", 32'(doutb0), 32'h66);

        // Write modes on port A.
        write_a(4'd7, 8'h11);
        read_both(4'd2, 4'd7);
        cea  = 1'b1;
        wrea = 1'b1;
        ada  = 4'd7;
        dina = 8'h22;
        step();
        idle();
        step();
        check_eq("wma_normal", 32'(douta0), 32'hA5);
        check_eq("wma_through", 32'(douta1), 32'h22);
        check_eq("wma_readfirst", 32'(douta2), 32'h11);

        // Write modes on port B (prior doutb is 11 from the read of addr 7).
        ceb  = 1'b1;
        wreb = 1'b1;
        adb  = 4'd8;
        dinb = 8'h81;
        step();
        idle();
        step();
        check_eq("wmb_normal", 32'(doutb0), 32'h11);
        check_eq("wmb_through", 32'(doutb1), 32'h81);
        check_eq("wmb_readfirst", 32'(doutb2), 32'hA5);

        // Same-address collision: A wins, pulse lasts one cycle.
        cea  = 1'b1;
        ceb  = 1'b1;
        wrea = 1'b1;
        wreb = 1'b1;
        ada  = 4'd9;
        adb  = 4'd9;
        dina = 8'hAA;
        dinb = 8'hBB;
        step();
        idle();
        check_eq("col_pulse", 32'(col0), 32'd1);
        check_eq("col_pulse_m2", 32'(col2), 32'd1);
        step();
        check_eq("col_clear", 32'(col0), 32'd0);
        check_eq("col_b_through", 32'(doutb1), 32'hBB);
        check_eq("col_b_readfirst", 32'(doutb2), 32'hA5);
        check_eq("col_a_through", 32'(douta1), 32'hAA);
        read_both(4'd9, 4'd9);
        check_eq("col_stored_a", 32'(douta0), 32'hAA);
        check_eq("col_stored_b", 32'(doutb0), 32'hAA);

        // Different addresses written together are independent.
        cea  = 1'b1;
        ceb  = 1'b1;
        wrea = 1'b1;
        wreb = 1'b1;
        ada  = 4'd10;
        adb  = 4'd11;
        dina = 8'h10;
        dinb = 8'h11;
        step();
        idle();
        check_eq("nocol_pulse", 32'(col0), 32'd0);
        read_both(4'd10, 4'd11);
        check_eq("nocol_a", 32'(douta0), 32'h10);
        check_eq("nocol_b", 32'(doutb0), 32'h11);

        // Cross-port write/read of one address returns the old data.
        write_a(4'd3, 8'h44);
        cea  = 1'b1;
        wrea = 1'b1;
        ada  = 4'd3;
        dina = 8'h77;
        ceb  = 1'b1;
        adb  = 4'd3;
        step();
        idle();
        step();
        check_eq("xread_old", 32'(doutb0), 32'h44);
        check_eq("xread_old_m2", 32'(doutb2), 32'h44);
        read_both(4'd3, 4'd3);
        check_eq("xread_new_a", 32'(douta0), 32'h77);
        check_eq("xread_new_b", 32'(doutb0), 32'h77);

        // Reset, then reset again part-way through the sweep.
        resetn = 1'b0;
        step();
        check_eq("rst2_douta", 32'(douta0), 32'h0);
        check_eq("rst2_busy", 32'(busy1), 32'd1);
        resetn = 1'b1;
        for (int i = 0; i < 8; i++) step();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        sweep_window("resweep_busy");
        read_both(4'd9, 4'd15);
        check_eq("resweep_addr9", 32'(douta0), 32'hA5);
        check_eq("resweep_addr15", 32'(doutb0), 32'hA5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
